// File: rtl/mac_array_seq.sv
// mac_array_seq
//   Run sequencer for a row x col MAC array. An accepted start walks the
//   array through kernel load, a settle gap, input streaming and an output
//   drain, issuing weight/activation SRAM reads and output FIFO writes.
//
// Ports
//   clk, reset           rising-edge clock, asynchronous active-low reset
//   start, abort         run request (IDLE only) / synchronous cancel
//   exec_len             number of input vectors per run (0 is rejected)
//   mode_cfg,
//   data_mode_cfg        per-run array configuration, latched on start
//   valid_in             valid bus from the array; only the last column is used
//   inst_w               array instruction: [1] execute, [0] kernel load
//   mode, data_mode      latched configuration
//   w_rd_en/w_rd_addr    weight SRAM read port
//   x_rd_en/x_rd_addr    activation SRAM read port
//   o_wr_en              output FIFO write strobe
//   busy, done, err      run status; done and err are one-cycle pulses
//
// All outputs are registered, so o_wr_en follows the sampled valid_in by
// one cycle.
module mac_array_seq #(
  parameter int row     = 8,
  parameter int col     = 8,
  parameter int len_bw  = 8,
  parameter int addr_bw = 11
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               abort,
  input  logic [len_bw-1:0]  exec_len,
  input  logic               mode_cfg,
  input  logic               data_mode_cfg,
  input  logic [col-1:0]     valid_in,
  output logic [1:0]         inst_w,
  output logic               mode,
  output logic               data_mode,
  output logic               w_rd_en,
  output logic [addr_bw-1:0] w_rd_addr,
  output logic               x_rd_en,
  output logic [addr_bw-1:0] x_rd_addr,
  output logic               o_wr_en,
  output logic               busy,
  output logic               done,
  output logic               err
);

  // state    | meaning
  // st_idle  | waiting for start
  // st_kload | kernel load, one weight row per cycle
  // st_kgap  | let the load instruction reach the last row
  // st_exec  | stream exec_len activation vectors
  // st_drain | collect remaining outputs, watchdog running
  // st_done  | one-cycle completion
  localparam logic [2:0] st_idle  = 3'd0;
  localparam logic [2:0] st_kload = 3'd1;
  localparam logic [2:0] st_kgap  = 3'd2;
  localparam logic [2:0] st_exec  = 3'd3;
  localparam logic [2:0] st_drain = 3'd4;
  localparam logic [2:0] st_done  = 3'd5;

  localparam int to_cyc = row + col + 4;
  localparam int to_bw  = $clog2(to_cyc) + 1;
  localparam int tw     = (len_bw > to_bw) ? len_bw : to_bw;

  logic [2:0]        st;
  logic [tw-1:0]     tmr;
  logic [len_bw-1:0] len_q;
  logic [15:0]       vcnt;
  logic [15:0]       vcnt_nxt;
  logic              v_take;
  logic              drain_hit;
  logic              unused_valid;

  // Only the last column's valid marks a finished output vector.
  assign unused_valid = ^{1'b0, valid_in};

  // Outputs beyond the run length are neither counted nor written.
  always_comb begin
    v_take    = valid_in[col-1] && (vcnt < 16'(len_q));
    vcnt_nxt  = vcnt + 16'(v_take);
    drain_hit = (vcnt_nxt >= 16'(len_q));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st        <= st_idle;
      tmr       <= '0;
      len_q     <= '0;
      vcnt      <= '0;
      inst_w    <= 2'b00;
      mode      <= 1'b0;
      data_mode <= 1'b0;
      w_rd_en   <= 1'b0;
      w_rd_addr <= '0;
      x_rd_en   <= 1'b0;
      x_rd_addr <= '0;
      o_wr_en   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      done    <= 1'b0;
      err     <= 1'b0;
      o_wr_en <= 1'b0;
      if (st != st_idle && abort) begin
        st        <= st_idle;
        inst_w    <= 2'b00;
        w_rd_en   <= 1'b0;
        w_rd_addr <= '0;
        x_rd_en   <= 1'b0;
        x_rd_addr <= '0;
        busy      <= 1'b0;
        err       <= 1'b1;
      end else begin
        case (st)
          st_idle: begin
            if (start && !abort) begin
              if (exec_len == '0) begin
                err <= 1'b1;
              end else begin
                st        <= st_kload;
                len_q     <= exec_len;
                mode      <= mode_cfg;
                data_mode <= data_mode_cfg;
                vcnt      <= '0;
                tmr       <= tw'(row - 1);
                inst_w    <= 2'b01;
                w_rd_en   <= 1'b1;
                w_rd_addr <= '0;
                busy      <= 1'b1;
              end
            end
          end
          st_kload: begin
            if (tmr == '0) begin
              st        <= st_kgap;
              inst_w    <= 2'b00;
              w_rd_en   <= 1'b0;
              w_rd_addr <= '0;
              // skewed delivery needs row cycles to reach the last row
              tmr       <= data_mode ? '0 : tw'(row - 1);
            end else begin
              tmr       <= tmr - tw'(1);
              w_rd_addr <= w_rd_addr + addr_bw'(1);
            end
          end
          st_kgap: begin
            if (tmr == '0) begin
              st        <= st_exec;
              inst_w    <= 2'b10;
              x_rd_en   <= 1'b1;
              x_rd_addr <= '0;
              tmr       <= tw'(len_q) - tw'(1);
            end else begin
              tmr <= tmr - tw'(1);
            end
          end
          st_exec: begin
            vcnt    <= vcnt_nxt;
            o_wr_en <= v_take;
            if (tmr == '0) begin
              st        <= st_drain;
              inst_w    <= 2'b00;
              x_rd_en   <= 1'b0;
              x_rd_addr <= '0;
              tmr       <= tw'(to_cyc - 1);
            end else begin
              tmr       <= tmr - tw'(1);
              x_rd_addr <= x_rd_addr + addr_bw'(1);
            end
          end
          st_drain: begin
            vcnt    <= vcnt_nxt;
            o_wr_en <= v_take;
            if (drain_hit) begin
              st   <= st_done;
              done <= 1'b1;
            end else if (valid_in[col-1]) begin
              tmr <= tw'(to_cyc - 1);
            end else if (tmr == '0) begin
              st   <= st_done;
              done <= 1'b1;
              err  <= 1'b1;
            end else begin
              tmr <= tmr - tw'(1);
            end
          end
          st_done: begin
            st   <= st_idle;
            busy <= 1'b0;
          end
          default: begin
            st   <= st_idle;
            busy <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mac_array_seq.sv
// tb_mac_array_seq
//   Randomized bench for mac_array_seq. A run-level reference model derives
//   the expected output word for every cycle from the cycle index within the
//   run (load, gap, execute, drain windows) plus counts of accepted valids
//   and idle drain cycles. Every cycle the full output word is compared.
module tb_mac_array_seq;

  localparam int ROW = 8;
  localparam int COL = 8;
  localparam int TO  = ROW + COL + 4;

  logic        clk;
  logic        reset;
  logic        start;
  logic        abort;
  logic [7:0]  exec_len;
  logic        mode_cfg;
  logic        data_mode_cfg;
  logic [7:0]  valid_in;
  logic [1:0]  inst_w;
  logic        mode;
  logic        data_mode;
  logic        w_rd_en;
  logic [10:0] w_rd_addr;
  logic        x_rd_en;
  logic [10:0] x_rd_addr;
  logic        o_wr_en;
  logic        busy;
  logic        done;
  logic        err;

  mac_array_seq #(.row(ROW), .col(COL), .len_bw(8), .addr_bw(11)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .exec_len(exec_len), .mode_cfg(mode_cfg), .data_mode_cfg(data_mode_cfg),
    .valid_in(valid_in), .inst_w(inst_w), .mode(mode), .data_mode(data_mode),
    .w_rd_en(w_rd_en), .w_rd_addr(w_rd_addr), .x_rd_en(x_rd_en),
    .x_rd_addr(x_rd_addr), .o_wr_en(o_wr_en), .busy(busy), .done(done),
    .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] obs_vec;
  assign obs_vec = {inst_w, mode, data_mode, w_rd_en, w_rd_addr, x_rd_en,
                    x_rd_addr, o_wr_en, busy, done, err};

  int n_vec = 0;
  int n_err = 0;
  int run_id = 0;

  // reference model state
  bit m_run, m_dn, m_mode, m_dm, e_o, e_done, e_err;
  int m_t, m_len, m_gap, m_taken, m_idle;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, got, want);
    end
  endtask

  function automatic logic [31:0] model_vec();
    int xs;
    logic [1:0] iw;
    logic we, xe;
    logic [10:0] wa, xa;
    xs = ROW + m_gap;
    iw = 2'b00; we = 1'b0; xe = 1'b0; wa = '0; xa = '0;
    if (m_run) begin
      if (m_t < ROW) begin
        iw = 2'b01; we = 1'b1; wa = 11'(m_t);
      end else if (m_t >= xs && m_t < xs + m_len) begin
        iw = 2'b10; xe = 1'b1; xa = 11'(m_t - xs);
      end
    end
    return {iw, m_mode, m_dm, we, wa, xe, xa, e_o, (m_run | m_dn), e_done, e_err};
  endfunction

  task automatic model_reset();
    m_run = 0; m_dn = 0; m_mode = 0; m_dm = 0;
    e_o = 0; e_done = 0; e_err = 0;
    m_t = 0; m_len = 0; m_gap = ROW; m_taken = 0; m_idle = 0;
  endtask

  // advance the model by one clock with the inputs sampled at that edge
  task automatic model_step(input bit s, input bit a, input int l,
                            input bit mc, input bit dmc, input bit v);
    int xs;
    bit in_x, in_d, fin;
    e_o = 0; e_done = 0; e_err = 0;
    if (m_dn) begin
      m_dn = 0;
      e_err = a;
    end else if (!m_run) begin
      if (s && !a) begin
        if (l == 0) e_err = 1;
        else begin
          m_run = 1; m_t = 0; m_len = l; m_mode = mc; m_dm = dmc;
          m_gap = dmc ? 1 : ROW; m_taken = 0; m_idle = 0;
        end
      end
    end else if (a) begin
      m_run = 0;
      e_err = 1;
    end else begin
      xs = ROW + m_gap;
      in_x = (m_t >= xs) && (m_t < xs + m_len);
      in_d = (m_t >= xs + m_len);
      if ((in_x || in_d) && v && m_taken < m_len) begin
        m_taken++;
        e_o = 1;
      end
      fin = 0;
      if (in_d) begin
        if (m_taken == m_len) fin = 1;
        else begin
          m_idle = v ? 0 : m_idle + 1;
          if (m_idle == TO) begin
            fin = 1;
            e_err = 1;
          end
        end
      end
      if (fin) begin
        m_run = 0; m_dn = 1; e_done = 1;
      end else begin
        m_t++;
      end
    end
  endtask

  task automatic tick(input bit s, input bit a, input int l, input bit mc,
                      input bit dmc, input bit v);
    start = s; abort = a; exec_len = 8'(l);
    mode_cfg = mc; data_mode_cfg = dmc;
    valid_in = {v, 7'($urandom)};
    @(posedge clk);
    model_step(s, a, l, mc, dmc, v);
    @(negedge clk);
    check_eq($sformatf("run%0d_t%0d", run_id, m_t), obs_vec, model_vec());
  endtask

  task automatic run_case(input int l, input bit mc, input bit dmc, input int vp,
                          input bit d_only, input int ab_t, input bit noisy);
    bit s, a, v, in_d;
    run_id++;
    tick(1'b1, 1'b0, l, mc, dmc, 1'b0);
    for (int c = 0; c < 700 && (m_run || m_dn); c++) begin
      in_d = m_run && (m_t >= ROW + m_gap + m_len);
      v = ($urandom_range(99) < vp) && (!d_only || in_d);
      a = (m_run && m_t == ab_t) || (noisy && $urandom_range(39) == 0);
      s = noisy && ($urandom_range(3) == 0);
      tick(s, a, int'($urandom_range(20)), 1'($urandom_range(1)),
           1'($urandom_range(1)), v);
    end
    check_eq("run_budget", {31'b0, (m_run | m_dn)}, 32'b0);
    tick(1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    model_reset();
    reset = 1'b0; start = 0; abort = 0; exec_len = 0;
    mode_cfg = 0; data_mode_cfg = 0; valid_in = 0;
    #12;
    check_eq("reset", obs_vec, 32'b0);
    @(negedge clk);
    reset = 1'b1;
    tick(1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0);

    run_case(4, 1'b0, 1'b0, 100, 1'b1, -1, 1'b0);             // basic skewed run
    run_case(1, 1'b1, 1'b1, 100, 1'b1, -1, 1'b0);             // broadcast, 1-cycle gap
    run_case(0, 1'b0, 1'b1, 0, 1'b1, -1, 1'b0);               // zero length rejected
    run_case(6, 1'b0, 1'b0, 100, 1'b0, ROW + ROW + 2, 1'b0);  // abort in 3rd exec cycle
    run_case(5, 1'b1, 1'b0, 0, 1'b1, -1, 1'b0);               // drain watchdog
    run_case(3, 1'b0, 1'b1, 100, 1'b0, -1, 1'b0);             // outputs during exec

    tick(1'b0, 1'b1, 4, 1'b1, 1'b1, 1'b1);                    // abort alone in idle
    tick(1'b1, 1'b1, 4, 1'b1, 1'b1, 1'b0);                    // abort beats start
    tick(1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0);

    // asynchronous reset in the middle of kernel load
    run_id++;
    tick(1'b1, 1'b0, 7, 1'b1, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    #2 reset = 1'b0;
    #1 check_eq("reset_mid_kload", obs_vec, 32'b0);
    model_reset();
    @(negedge clk);
    #2 reset = 1'b1;
    run_case(3, 1'b1, 1'b1, 60, 1'b0, -1, 1'b0);

    run_case(255, 1'b0, 1'b1, 100, 1'b0, -1, 1'b0);           // long run, no wrap

    for (int r = 0; r < 40; r++) begin
      int vps[4] = '{0, 30, 70, 100};
      int ab;
      ab = ($urandom_range(3) == 0) ? int'($urandom_range(40)) : -1;
      run_case(int'($urandom_range(20)), 1'($urandom_range(1)), 1'($urandom_range(1)),
               vps[$urandom_range(3)], 1'($urandom_range(1)), ab, 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
